// File: rtl/comparator_bank.sv
// comparator_bank
// NUM_CH compare/operation channels evaluated against one shared timer counter.
// Each channel drives a polarity-adjusted output and its complement.
// Configuration is double-buffered so an update can be deferred to the period end.
// Optional dead-time insertion on the outputs is enabled by defining
// COMP_BANK_DEADTIME_EN. Without it the outputs are combinational from the
// channel state and cfg_deadtime_i is ignored.
module comparator_bank #(
    parameter int NUM_BITS = 16,
    parameter int NUM_CH   = 4,
    parameter int DT_BITS  = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       ctrl_active_i,
    input  logic                       ctrl_update_i,
    input  logic                       ctrl_rst_i,
    input  logic                       cfg_sync_update_i,
    input  logic [NUM_CH*NUM_BITS-1:0] cfg_comp_i,
    input  logic [NUM_CH*3-1:0]        cfg_comp_op_i,
    input  logic [NUM_CH-1:0]          cfg_invert_i,
    input  logic [DT_BITS-1:0]         cfg_deadtime_i,
    input  logic                       timer_end_i,
    input  logic                       timer_valid_i,
    input  logic                       timer_sawtooth_i,
    input  logic [NUM_BITS-1:0]        timer_count_i,
    output logic [NUM_CH-1:0]          result_o,
    output logic [NUM_CH-1:0]          result_n_o,
    output logic                       update_pending_o
);

    localparam logic [2:0] OP_SET    = 3'b000;
    localparam logic [2:0] OP_TOGRST = 3'b001;
    localparam logic [2:0] OP_SETRST = 3'b010;
    localparam logic [2:0] OP_TOG    = 3'b011;
    localparam logic [2:0] OP_RST    = 3'b100;
    localparam logic [2:0] OP_TOGSET = 3'b101;
    localparam logic [2:0] OP_RSTSET = 3'b110;
    localparam logic [2:0] OP_HOLD   = 3'b111;

    logic [NUM_BITS-1:0] act_comp [NUM_CH];
    logic [2:0]          act_op   [NUM_CH];
    logic [NUM_BITS-1:0] shd_comp [NUM_CH];
    logic [2:0]          shd_op   [NUM_CH];
    logic                pending;
    logic [NUM_CH-1:0]   r_value;
    logic [NUM_CH-1:0]   is_2nd;
    logic [NUM_CH-1:0]   nxt_value;
    logic [NUM_CH-1:0]   nxt_2nd;
    logic [NUM_CH-1:0]   match;
    logic [NUM_CH-1:0]   p;

    logic state_en;
    logic transfer;
    logic load_now;
    logic defer;

    // A reset of channel state wins over a pending transfer; a request that
    // coincides with a transfer (or a reset) goes straight to the active set.
    assign state_en = timer_valid_i & ctrl_active_i & ~ctrl_rst_i;
    assign transfer = pending & timer_valid_i & timer_end_i & ~ctrl_rst_i;
    assign load_now = ctrl_update_i &
                      (~cfg_sync_update_i | ~ctrl_active_i | ctrl_rst_i | transfer);
    assign defer    = ctrl_update_i & ~load_now;

    // First action of a two-event op.
    function automatic logic first_act(input logic [2:0] op, input logic v);
        case (op)
            OP_TOGRST, OP_TOGSET: first_act = ~v;
            OP_SETRST:            first_act = 1'b1;
            OP_RSTSET:            first_act = 1'b0;
            default:              first_act = v;
        endcase
    endfunction

    // Second action of a two-event op.
    function automatic logic second_act(input logic [2:0] op, input logic v);
        case (op)
            OP_TOGRST, OP_SETRST: second_act = 1'b0;
            OP_TOGSET, OP_RSTSET: second_act = 1'b1;
            default:              second_act = v;
        endcase
    endfunction

    // Per-channel next value from the pre-edge active compare/op registers.
    always_comb begin
        nxt_value = r_value;
        nxt_2nd   = is_2nd;
        match     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            match[c] = timer_valid_i && (act_comp[c] == timer_count_i);
            case (act_op[c])
                OP_SET: if (match[c]) nxt_value[c] = 1'b1;
                OP_TOG: if (match[c]) nxt_value[c] = ~r_value[c];
                OP_RST: if (match[c]) nxt_value[c] = 1'b0;
                OP_HOLD: nxt_2nd[c] = 1'b0;
                default: begin
                    if (timer_sawtooth_i) begin
                        // Match has priority over the period end.
                        if (match[c])
                            nxt_value[c] = first_act(act_op[c], r_value[c]);
                        else if (timer_end_i)
                            nxt_value[c] = second_act(act_op[c], r_value[c]);
                    end else if (match[c]) begin
                        nxt_value[c] = is_2nd[c] ? second_act(act_op[c], r_value[c])
                                                 : first_act(act_op[c], r_value[c]);
                        nxt_2nd[c]   = ~is_2nd[c];
                    end
                end
            endcase
        end
    end

    // Channel state: value and second-event flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_value <= '0;
            is_2nd  <= '0;
        end else if (ctrl_rst_i) begin
            r_value <= '0;
            is_2nd  <= '0;
        end else begin
            if (state_en) begin
                r_value <= nxt_value;
                is_2nd  <= nxt_2nd;
            end
            if (load_now || transfer)
                is_2nd <= '0;
        end
    end

    // Active and shadow configuration banks.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                act_comp[c] <= '0;
                act_op[c]   <= '0;
                shd_comp[c] <= '0;
                shd_op[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (load_now) begin
                    act_comp[c] <= cfg_comp_i[c*NUM_BITS +: NUM_BITS];
                    act_op[c]   <= cfg_comp_op_i[c*3 +: 3];
                end else if (transfer) begin
                    act_comp[c] <= shd_comp[c];
                    act_op[c]   <= shd_op[c];
                end
                if (defer) begin
                    shd_comp[c] <= cfg_comp_i[c*NUM_BITS +: NUM_BITS];
                    shd_op[c]   <= cfg_comp_op_i[c*3 +: 3];
                end
            end
        end
    end

    // Pending flag: set by a deferred request, cleared by any load into active.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            pending <= 1'b0;
        else if (ctrl_rst_i || load_now)
            pending <= 1'b0;
        else if (defer)
            pending <= 1'b1;
        else if (transfer)
            pending <= 1'b0;
    end

    assign update_pending_o = pending;
    assign p = r_value ^ cfg_invert_i;

`ifdef COMP_BANK_DEADTIME_EN
    logic [NUM_CH-1:0]  p_q;
    logic [NUM_CH-1:0]  res_q;
    logic [NUM_CH-1:0]  res_n_q;
    logic [DT_BITS-1:0] dt_cnt [NUM_CH];

    // Dead-time insertion: on a change of p both outputs go low for
    // cfg_deadtime_i cycles; a further change during the gap restarts it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            p_q     <= '0;
            res_q   <= '0;
            res_n_q <= '0;
            for (int c = 0; c < NUM_CH; c++)
                dt_cnt[c] <= '0;
        end else if (ctrl_rst_i) begin
            p_q     <= '0;
            res_q   <= '0;
            res_n_q <= '0;
            for (int c = 0; c < NUM_CH; c++)
                dt_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (p[c] != p_q[c]) begin
                    p_q[c] <= p[c];
                    if (cfg_deadtime_i == '0) begin
                        res_q[c]   <= p[c];
                        res_n_q[c] <= ~p[c];
                        dt_cnt[c]  <= '0;
                    end else begin
                        res_q[c]   <= 1'b0;
                        res_n_q[c] <= 1'b0;
                        dt_cnt[c]  <= cfg_deadtime_i;
                    end
                end else if (dt_cnt[c] != '0) begin
                    dt_cnt[c] <= dt_cnt[c] - DT_BITS'(1);
                    if (dt_cnt[c] == DT_BITS'(1)) begin
                        res_q[c]   <= p[c];
                        res_n_q[c] <= ~p[c];
                    end
                end else begin
                    res_q[c]   <= p[c];
                    res_n_q[c] <= ~p[c];
                end
            end
        end
    end

    assign result_o   = res_q;
    assign result_n_o = res_n_q;
`else
    logic unused_deadtime;
    assign unused_deadtime = ^cfg_deadtime_i;

    assign result_o   = p;
    assign result_n_o = ~p;
`endif

endmodule

// File: tb/tb_comparator_bank.sv
// Directed bench for comparator_bank (NUM_BITS=16, NUM_CH=4, DT_BITS=8).
// Expected outputs are queued when a step is driven and checked after the edge.
module tb_comparator_bank;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        ctrl_active_i;
    logic        ctrl_update_i;
    logic        ctrl_rst_i;
    logic        cfg_sync_update_i;
    logic [63:0] cfg_comp_i;
    logic [11:0] cfg_comp_op_i;
    logic [3:0]  cfg_invert_i;
    logic [7:0]  cfg_deadtime_i;
    logic        timer_end_i;
    logic        timer_valid_i;
    logic        timer_sawtooth_i;
    logic [15:0] timer_count_i;
    logic [3:0]  result_o;
    logic [3:0]  result_n_o;
    logic        update_pending_o;

    logic [15:0] comp [4];
    logic [2:0]  op   [4];

    typedef struct {
        string      tag;
        logic [3:0] res;
        logic [3:0] res_n;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    comparator_bank #(.NUM_BITS(16), .NUM_CH(4), .DT_BITS(8)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .ctrl_active_i    (ctrl_active_i),
        .ctrl_update_i    (ctrl_update_i),
        .ctrl_rst_i       (ctrl_rst_i),
        .cfg_sync_update_i(cfg_sync_update_i),
        .cfg_comp_i       (cfg_comp_i),
        .cfg_comp_op_i    (cfg_comp_op_i),
        .cfg_invert_i     (cfg_invert_i),
        .cfg_deadtime_i   (cfg_deadtime_i),
        .timer_end_i      (timer_end_i),
        .timer_valid_i    (timer_valid_i),
        .timer_sawtooth_i (timer_sawtooth_i),
        .timer_count_i    (timer_count_i),
        .result_o         (result_o),
        .result_n_o       (result_n_o),
        .update_pending_o (update_pending_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        cfg_comp_i    = '0;
        cfg_comp_op_i = '0;
        for (int c = 0; c < 4; c++) begin
            cfg_comp_i[c*16 +: 16] = comp[c];
            cfg_comp_op_i[c*3 +: 3] = op[c];
        end
    end

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of timer/control inputs, then check the post-edge outputs.
    task automatic step(input int cnt, input logic valid, input logic tend,
                        input logic upd, input logic rst,
                        input logic [3:0] eres, input logic [3:0] eres_n,
                        input logic epend, input string tag);
        exp_t e;
        timer_count_i = 16'(cnt);
        timer_valid_i = valid;
        timer_end_i   = tend;
        ctrl_update_i = upd;
        ctrl_rst_i    = rst;
        e.tag = tag; e.res = eres; e.res_n = eres_n; e.pend = epend;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        ctrl_update_i = 1'b0;
        ctrl_rst_i    = 1'b0;
        e = sb.pop_front();
        chk4({e.tag, " result_o"}, result_o, e.res);
        chk4({e.tag, " result_n_o"}, result_n_o, e.res_n);
        chk1({e.tag, " pending"}, update_pending_o, e.pend);
    endtask

    // Combinational-output build: result_n_o is always the complement.
    task automatic stepc(input int cnt, input logic valid, input logic tend,
                         input logic upd, input logic rst,
                         input logic [3:0] eres, input logic epend, input string tag);
        step(cnt, valid, tend, upd, rst, eres, ~eres, epend, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        rstn_i = 1'b0;
        ctrl_active_i = 1'b0; ctrl_update_i = 1'b0; ctrl_rst_i = 1'b0;
        cfg_sync_update_i = 1'b0; cfg_invert_i = 4'b0000; cfg_deadtime_i = 8'd0;
        timer_end_i = 1'b0; timer_valid_i = 1'b0; timer_sawtooth_i = 1'b1;
        timer_count_i = '0;
        for (int c = 0; c < 4; c++) begin
            comp[c] = 16'hFFFF;
            op[c]   = 3'b111;
        end
        #3;

`ifndef COMP_BANK_DEADTIME_EN
        chk4("reset result_o", result_o, 4'b0000);
        chk4("reset result_n_o", result_n_o, 4'b1111);
        chk1("reset pending", update_pending_o, 1'b0);
        cfg_invert_i = 4'b0101;
        #1;
        chk4("reset invert result_o", result_o, 4'b0101);
        chk4("reset invert result_n_o", result_n_o, 4'b1010);
        cfg_invert_i = 4'b0000;
        @(negedge clk_i);
        rstn_i = 1'b1;

        comp[0] = 16'd5; op[0] = 3'b000;
        comp[1] = 16'd3; op[1] = 3'b010;
        comp[2] = 16'd4; op[2] = 3'b001;
        ctrl_active_i = 1'b0; cfg_sync_update_i = 1'b1;
        stepc(0, 0, 0, 1, 0, 4'b0000, 1'b0, "load idle");
        ctrl_active_i = 1'b1;

        for (int pr = 0; pr < 2; pr++)
            for (int k = 0; k < 8; k++) begin
                e = 4'b0000;
                e[0] = (pr == 1) || (k >= 5);
                e[1] = (k >= 3) && (k < 7);
                e[2] = (k >= 4) && (k < 7);
                stepc(k, 1, k == 7, 0, 0, e, 1'b0, "saw");
            end
        stepc(0, 0, 0, 0, 1, 4'b0000, 1'b0, "ctrl_rst");

        timer_sawtooth_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            int  k;
            logic up;
            up = (i < 8);
            k  = up ? i : 14 - i;
            e = 4'b0000;
            e[0] = up ? (k >= 5) : 1'b1;
            e[1] = up ? (k >= 3) : (k > 3);
            e[2] = up ? (k >= 4) : (k > 4);
            stepc(k, 1, 0, 0, 0, e, 1'b0, "updown");
        end
        for (int k = 0; k < 6; k++) begin
            e = 4'b0001;
            e[1] = (k >= 3);
            e[2] = (k >= 4);
            stepc(k, 1, 0, 0, 0, e, 1'b0, "updown2 up");
        end
        stepc(5, 0, 0, 0, 1, 4'b0000, 1'b0, "ctrl_rst mid");
        for (int k = 5; k > 1; k--) begin
            e = 4'b0001;
            e[1] = (k <= 3);
            e[2] = (k <= 4);
            stepc(k, 1, 0, 0, 0, e, 1'b0, "updown2 down");
        end
        stepc(0, 0, 0, 0, 1, 4'b0000, 1'b0, "ctrl_rst 2");

        timer_sawtooth_i = 1'b1;
        comp[0] = 16'd5; op[0] = 3'b010;
        ctrl_active_i = 1'b0;
        stepc(0, 0, 0, 1, 0, 4'b0000, 1'b0, "imm load");
        ctrl_active_i = 1'b1; cfg_sync_update_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) comp[0] = 16'd2;
            e = 4'b0000;
            e[0] = (k >= 5) && (k < 7);
            e[1] = (k >= 3) && (k < 7);
            e[2] = (k >= 4) && (k < 7);
            stepc(k, 1, k == 7, k == 1, 0, e, (k >= 1) && (k < 7), "defer A");
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 1) comp[0] = 16'd6;
            if (k == 7) comp[0] = 16'd3;
            e = 4'b0000;
            e[0] = (k >= 2) && (k < 7);
            e[1] = (k >= 3) && (k < 7);
            e[2] = (k >= 4) && (k < 7);
            stepc(k, 1, k == 7, (k == 1) || (k == 7), 0, e, (k >= 1) && (k < 7), "defer B");
        end
        for (int k = 0; k < 8; k++) begin
            e = 4'b0000;
            e[0] = (k >= 3) && (k < 7);
            e[1] = (k >= 3) && (k < 7);
            e[2] = (k >= 4) && (k < 7);
            stepc(k, 1, k == 7, 0, 0, e, 1'b0, "defer C");
        end

        comp[3] = 16'd2; op[3] = 3'b000;
        cfg_sync_update_i = 1'b0;
        stepc(0, 0, 0, 1, 0, 4'b0000, 1'b0, "imm load active");
        for (int k = 0; k < 8; k++) begin
            e = 4'b0000;
            e[0] = (k >= 3) && (k < 7);
            e[1] = (k >= 3) && (k < 7);
            e[2] = (k >= 4) && (k < 7);
            e[3] = (k >= 2);
            stepc(k, 1, k == 7, 0, 0, e, 1'b0, "set ch3");
        end
        op[3] = 3'b111;
        stepc(0, 0, 0, 1, 0, 4'b1000, 1'b0, "load hold");
        for (int k = 0; k < 8; k++) begin
            e = 4'b1000;
            e[0] = (k >= 3) && (k < 7);
            e[1] = (k >= 3) && (k < 7);
            e[2] = (k >= 4) && (k < 7);
            stepc(k, 1, k == 7, 0, 0, e, 1'b0, "hold");
        end
        comp[3] = 16'd6; op[3] = 3'b000;
        cfg_sync_update_i = 1'b1;
        stepc(0, 0, 0, 1, 0, 4'b1000, 1'b1, "defer before rst");
        stepc(0, 0, 0, 1, 1, 4'b0000, 1'b0, "rst with update");
        for (int k = 0; k < 8; k++) begin
            e = 4'b0000;
            e[0] = (k >= 3) && (k < 7);
            e[1] = (k >= 3) && (k < 7);
            e[2] = (k >= 4) && (k < 7);
            e[3] = (k >= 6);
            stepc(k, 1, k == 7, 0, 0, e, 1'b0, "after rst load");
        end
`else
        cfg_invert_i = 4'b0101;
        #1;
        chk4("dt reset result_o", result_o, 4'b0000);
        chk4("dt reset result_n_o", result_n_o, 4'b0000);
        chk1("dt reset pending", update_pending_o, 1'b0);
        cfg_invert_i = 4'b0000;
        @(negedge clk_i);
        rstn_i = 1'b1;

        comp[0] = 16'd2; op[0] = 3'b011;
        cfg_deadtime_i = 8'd3;
        ctrl_active_i = 1'b0;
        step(0, 0, 0, 1, 0, 4'b0000, 4'b1111, 1'b0, "dt load");
        ctrl_active_i = 1'b1;
        step(0, 1, 0, 0, 0, 4'b0000, 4'b1111, 1'b0, "dt cnt0");
        step(1, 1, 0, 0, 0, 4'b0000, 4'b1111, 1'b0, "dt cnt1");
        step(2, 1, 0, 0, 0, 4'b0000, 4'b1111, 1'b0, "dt match edge");
        step(3, 0, 0, 0, 0, 4'b0000, 4'b1110, 1'b0, "dt gap1");
        step(3, 0, 0, 0, 0, 4'b0000, 4'b1110, 1'b0, "dt gap2");
        step(3, 0, 0, 0, 0, 4'b0000, 4'b1110, 1'b0, "dt gap3");
        step(3, 0, 0, 0, 0, 4'b0001, 4'b1110, 1'b0, "dt swap");
        step(3, 0, 0, 0, 0, 4'b0001, 4'b1110, 1'b0, "dt steady");
        cfg_deadtime_i = 8'd0;
        step(2, 1, 0, 0, 0, 4'b0001, 4'b1110, 1'b0, "dt0 match edge");
        step(3, 0, 0, 0, 0, 4'b0000, 4'b1111, 1'b0, "dt0 follow");
        step(3, 0, 0, 0, 0, 4'b0000, 4'b1111, 1'b0, "dt0 steady");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
